ds3502_wiper_ramp: RTL and testbench
====================================

Name: ds3502_wiper_ramp

Overview:
- Upstream sequencer for the DS3502 I2C wiper writer.
- Accepts 7-bit wiper target codes from control logic and walks the pot toward each target in bounded steps, with a dwell between writes.
- Issues one single-cycle load per step to the writer and tracks its busy flag so no write is dropped or overlapped.
- Sits between the control/register logic and the DS3502 I2C writer; all of its writer-side outputs connect directly to that writer.

Parameters:
- STEP, 8, max code change per write (1..127).
- DWELL_CYCLES, 1700, clk cycles idle after each completed write before the next step (>=1).
- INIT_CODE, 64, code written unconditionally after reset, before any target is honoured.
- MAX_CODE, 127, upper clamp for targets and wiper code.
- TIMEOUT_CYCLES, 65535, busy-watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- tgt_valid  in  1  new target present.
- tgt_code  in  7  requested wiper code.
- tgt_ready  out  1  target accepted this cycle.
- wr_load  out  1  single-cycle load strobe to the writer.
- wr_value  out  8  value to the writer, {1'b0, step_code}; held stable from load until busy falls.
- wr_busy  in  1  writer busy flag.
- cur_code  out  7  last code whose write completed.
- at_target  out  1  cur_code == target and FSM idle.
- ramp_busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync release), all to these values:
  - FSM=INIT.
  - wr_load=0, wr_value=0.
  - cur_code=INIT_CODE, target=INIT_CODE.
  - at_target=0, ramp_busy=1, tgt_ready=0.
  - dwell counter=0.
- Target capture:
  - tgt_ready=1 in every state except INIT.
  - When tgt_valid && tgt_ready, target <= min(tgt_code, MAX_CODE).
  - A later target overwrites an earlier one. Only the latest target matters; intermediate targets are never queued.
- Step computation (combinational from cur_code and target):
  - |target-cur_code| <= STEP: next = target.
  - Otherwise next = cur_code ± STEP toward target.
  - Arithmetic is 8-bit unsigned with no wrap; the result is always within 0..MAX_CODE.
- FSM states:
  - INIT: step_code=INIT_CODE. Go to ISSUE once wr_busy==0. The writer holds busy high through its own reset, so the FSM waits there.
  - IDLE: if target!=cur_code, latch step_code=next and go to ISSUE. Otherwise at_target=1.
  - ISSUE: the cycle wr_busy==0, drive wr_load=1 for exactly one cycle with wr_value={0,step_code}, then go to ACCEPT.
  - ACCEPT: wait for wr_busy==1 (writer raises busy the cycle after load), then go to DONE.
  - DONE: wait for wr_busy==0. Then cur_code <= step_code, clear the dwell counter, go to DWELL.
  - DWELL: count to DWELL_CYCLES-1, then go to IDLE. A target change during DWELL takes effect at IDLE.
- Latency:
  - Target to load: 2 cycles when idle and the writer is free (capture, then IDLE, then ISSUE).
  - Per step: writer transaction time + DWELL_CYCLES + 2.
- Boundaries:
  - target==cur_code when accepted: no write; at_target stays 1.
  - Target changes mid-write: the in-flight step_code completes unchanged; the next step is recomputed from the new target.
  - Target reverses direction mid-ramp: the next step moves toward the new target; no overshoot beyond |STEP|.
  - tgt_code>MAX_CODE: clamped.
  - STEP>=127: single jump.
  - Reset mid-write: FSM returns to INIT and the writer is re-synchronised via the INIT write.
  - wr_load is never asserted while wr_busy==1.

Optional Feature:
- DS3502_RAMP_TIMEOUT_EN defined:
  - Adds a watchdog counter in ACCEPT and DONE, plus output err_timeout (1 bit, reset 0, sticky until reset).
  - If wr_busy does not make the expected transition within TIMEOUT_CYCLES, set err_timeout, leave cur_code unchanged, and go to IDLE.
  - A stuck-low busy in ACCEPT (writer missed the load) is retried via IDLE.
- Undefined: no watchdog, no err_timeout port; the FSM waits indefinitely.

Decomposition:
- Package ds3502_pkg:
  - FSM state enum (INIT, IDLE, ISSUE, ACCEPT, DONE, DWELL).
  - DS3502_MAX_CODE=127.
  - Default STEP and DWELL constants.
  - The wiper-code width (7).
- One natural sub-module, ds3502_step_calc: the combinational clamp/step function (cur, target, STEP → next). It is reused by the bench's reference model.

Test Plan:
- Reset release with wr_busy held high for 20 cycles, then low → exactly one wr_load with wr_value=0x40; cur_code=64 after busy falls; at_target=1.
- Target 100, STEP=8 → writes 72,80,88,96,100, each separated by ≥DWELL_CYCLES; at_target=1 only after 100 completes.
- Target 100, then target 10 while the write of 80 is in flight → 80 completes, then writes 72,64,...,16,10; no value >80 is written.
- Target 127, then tgt_code=127 again, then tgt_code issued as 7'h7F with the clamp checked by forcing MAX_CODE=120 → all writes ≤120, final 120; a repeated equal target causes no load.
- Writer model that delays busy rise by 3 cycles and holds busy for 500 cycles → wr_load is exactly one cycle, wr_value is stable until busy falls, and there is never a load while busy=1.
- With DS3502_RAMP_TIMEOUT_EN, TIMEOUT_CYCLES=100 and busy never rising → err_timeout=1 at cycle 100 of ACCEPT; cur_code is unchanged; a retry load is issued from IDLE.

Source files
------------

// File: rtl/ds3502_pkg.sv
// Shared types and constants for the DS3502 wiper ramp sequencer.
//   CODE_W               wiper code width (7)
//   WR_W                 writer value width (8, MSB always 0)
//   DS3502_MAX_CODE      highest legal wiper code
//   DEFAULT_*            default ramp parameters
//   ramp_state_e         sequencer FSM states
//   clamp_code()         saturate a code to an upper limit
package ds3502_pkg;

    localparam int unsigned CODE_W               = 7;
    localparam int unsigned WR_W                 = 8;
    localparam int unsigned DS3502_MAX_CODE      = 127;
    localparam int unsigned DEFAULT_STEP         = 8;
    localparam int unsigned DEFAULT_DWELL_CYCLES = 1700;
    localparam int unsigned DEFAULT_INIT_CODE    = 64;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_ACCEPT = 3'd3,
        ST_DONE   = 3'd4,
        ST_DWELL  = 3'd5
    } ramp_state_e;

    // Saturate a requested code to max_code.
    function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] code,
                                                     input logic [CODE_W-1:0] max_code);
        return (code > max_code) ? max_code : code;
    endfunction

endpackage

// File: rtl/ds3502_step_calc.sv
// Combinational next-step calculator for the wiper ramp.
// Moves cur_code toward target by at most STEP, never overshooting the
// target and never leaving 0..MAX_CODE.
//   cur_code     in   7  last completed wiper code
//   target       in   7  requested (already clamped) code
//   next_code_c  out  7  code for the next write (combinational)
module ds3502_step_calc
    import ds3502_pkg::*;
#(
    parameter int unsigned STEP     = DEFAULT_STEP,
    parameter int unsigned MAX_CODE = DS3502_MAX_CODE
) (
    input  logic [CODE_W-1:0] cur_code,
    input  logic [CODE_W-1:0] target,
    output logic [CODE_W-1:0] next_code_c
);

    localparam int unsigned CALC_W   = CODE_W + 1;
    // Out-of-range steps degrade to a single jump (or a unit step for 0).
    localparam int unsigned STEP_EFF = (STEP > DS3502_MAX_CODE) ? DS3502_MAX_CODE :
                                       (STEP == 0) ? 1 : STEP;
    localparam int unsigned MAX_EFF  = (MAX_CODE > DS3502_MAX_CODE) ? DS3502_MAX_CODE : MAX_CODE;

    logic [CALC_W-1:0] cur_w;
    logic [CALC_W-1:0] tgt_w;
    logic [CALC_W-1:0] diff;
    logic [CALC_W-1:0] next_w;

    // Unsigned 8-bit arithmetic; cur-STEP only taken when cur > target+STEP, so no wrap.
    always_comb begin
        cur_w = {1'b0, cur_code};
        tgt_w = {1'b0, target};
        if (tgt_w >= cur_w) begin
            diff   = tgt_w - cur_w;
            next_w = (diff <= CALC_W'(STEP_EFF)) ? tgt_w : cur_w + CALC_W'(STEP_EFF);
        end else begin
            diff   = cur_w - tgt_w;
            next_w = (diff <= CALC_W'(STEP_EFF)) ? tgt_w : cur_w - CALC_W'(STEP_EFF);
        end
        if (next_w > CALC_W'(MAX_EFF)) begin
            next_w = CALC_W'(MAX_EFF);
        end
        next_code_c = CODE_W'(next_w);
    end

endmodule

// File: rtl/ds3502_wiper_ramp.sv
// DS3502 wiper ramp sequencer: walks the pot toward the latest target in
// bounded steps, one writer transaction per step, with a dwell between writes.
// Optional busy watchdog enabled by defining DS3502_RAMP_TIMEOUT_EN.
//   clk          in   1  system clock
//   rst          in   1  asynchronous active-high reset
//   tgt_valid    in   1  new target present
//   tgt_code     in   7  requested wiper code
//   tgt_ready    out  1  target accepted this cycle (all states but INIT)
//   wr_load      out  1  single-cycle load strobe to the writer
//   wr_value     out  8  {1'b0, step_code}, held from load until busy falls
//   wr_busy      in   1  writer busy flag
//   cur_code     out  7  last code whose write completed
//   at_target    out  1  idle with cur_code == target
//   ramp_busy    out  1  FSM not idle
//   err_timeout  out  1  sticky watchdog flag (DS3502_RAMP_TIMEOUT_EN only)
module ds3502_wiper_ramp
    import ds3502_pkg::*;
#(
    parameter int unsigned STEP           = DEFAULT_STEP,
    parameter int unsigned DWELL_CYCLES   = DEFAULT_DWELL_CYCLES,
    parameter int unsigned INIT_CODE      = DEFAULT_INIT_CODE,
    parameter int unsigned MAX_CODE       = DS3502_MAX_CODE
`ifdef DS3502_RAMP_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tgt_valid,
    input  logic [CODE_W-1:0] tgt_code,
    output logic              tgt_ready,
    output logic              wr_load,
    output logic [WR_W-1:0]   wr_value,
    input  logic              wr_busy,
    output logic [CODE_W-1:0] cur_code,
    output logic              at_target,
    output logic              ramp_busy
`ifdef DS3502_RAMP_TIMEOUT_EN
    ,
    output logic              err_timeout
`endif
);

    localparam int unsigned MAX_EFF   = (MAX_CODE > DS3502_MAX_CODE) ? DS3502_MAX_CODE : MAX_CODE;
    localparam int unsigned INIT_EFF  = (INIT_CODE > MAX_EFF) ? MAX_EFF : INIT_CODE;
    localparam int unsigned DWELL_EFF = (DWELL_CYCLES == 0) ? 1 : DWELL_CYCLES;
    localparam int unsigned DWELL_W   = (DWELL_EFF > 1) ? $clog2(DWELL_EFF) : 1;

    localparam logic [CODE_W-1:0]  MAX_V      = CODE_W'(MAX_EFF);
    localparam logic [CODE_W-1:0]  INIT_V     = CODE_W'(INIT_EFF);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_EFF - 1);

`ifdef DS3502_RAMP_TIMEOUT_EN
    localparam int unsigned WD_EFF  = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
    localparam int unsigned WD_W    = (WD_EFF > 1) ? $clog2(WD_EFF) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_EFF - 1);

    logic [WD_W-1:0] wd_cnt, wd_cnt_d;
    logic            err_timeout_d;
`endif

    ramp_state_e        state, state_d;
    logic [CODE_W-1:0]  target, target_d;
    logic [CODE_W-1:0]  cur_code_d;
    logic [CODE_W-1:0]  step_code, step_code_d;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_d;
    logic               wr_load_d;
    logic [WR_W-1:0]    wr_value_d;
    logic               tgt_ready_d;
    logic               at_target_d;
    logic               ramp_busy_d;
    logic [CODE_W-1:0]  next_code_c;

    // Next wiper code toward the current target.
    ds3502_step_calc #(
        .STEP     (STEP),
        .MAX_CODE (MAX_EFF)
    ) u_step_calc (
        .cur_code    (cur_code),
        .target      (target),
        .next_code_c (next_code_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_INIT;
            target      <= INIT_V;
            cur_code    <= INIT_V;
            step_code   <= INIT_V;
            dwell_cnt   <= '0;
            wr_load     <= 1'b0;
            wr_value    <= '0;
            tgt_ready   <= 1'b0;
            at_target   <= 1'b0;
            ramp_busy   <= 1'b1;
`ifdef DS3502_RAMP_TIMEOUT_EN
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            target      <= target_d;
            cur_code    <= cur_code_d;
            step_code   <= step_code_d;
            dwell_cnt   <= dwell_cnt_d;
            wr_load     <= wr_load_d;
            wr_value    <= wr_value_d;
            tgt_ready   <= tgt_ready_d;
            at_target   <= at_target_d;
            ramp_busy   <= ramp_busy_d;
`ifdef DS3502_RAMP_TIMEOUT_EN
            wd_cnt      <= wd_cnt_d;
            err_timeout <= err_timeout_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        target_d    = target;
        cur_code_d  = cur_code;
        step_code_d = step_code;
        dwell_cnt_d = dwell_cnt;
        wr_load_d   = 1'b0;
        wr_value_d  = wr_value;
`ifdef DS3502_RAMP_TIMEOUT_EN
        wd_cnt_d      = wd_cnt;
        err_timeout_d = err_timeout;
`endif

        // Latest target wins; nothing is queued.
        if (tgt_valid && tgt_ready) begin
            target_d = clamp_code(tgt_code, MAX_V);
        end

        case (state)
            ST_INIT: begin
                // Writer holds busy through its own reset; wait it out.
                step_code_d = INIT_V;
                if (!wr_busy) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_IDLE: begin
                if (target != cur_code) begin
                    step_code_d = next_code_c;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!wr_busy) begin
                    wr_load_d  = 1'b1;
                    wr_value_d = {1'b0, step_code};
                    state_d    = ST_ACCEPT;
`ifdef DS3502_RAMP_TIMEOUT_EN
                    wd_cnt_d   = '0;
`endif
                end
            end
            ST_ACCEPT: begin
                if (wr_busy) begin
                    state_d = ST_DONE;
`ifdef DS3502_RAMP_TIMEOUT_EN
                    wd_cnt_d = '0;
                end else if (wd_cnt == WD_LAST) begin
                    // Writer never took the load; retry from IDLE.
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt + WD_W'(1);
`endif
                end
            end
            ST_DONE: begin
                if (!wr_busy) begin
                    cur_code_d  = step_code;
                    dwell_cnt_d = '0;
                    state_d     = ST_DWELL;
`ifdef DS3502_RAMP_TIMEOUT_EN
                end else if (wd_cnt == WD_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt + WD_W'(1);
`endif
                end
            end
            ST_DWELL: begin
                if (dwell_cnt == DWELL_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    dwell_cnt_d = dwell_cnt + DWELL_W'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Status flags track the state being entered so they line up with it.
        tgt_ready_d = (state_d != ST_INIT);
        ramp_busy_d = (state_d != ST_IDLE);
        at_target_d = (state_d == ST_IDLE) && (target_d == cur_code_d);
    end

endmodule

// File: tb/tb_ds3502_wiper_ramp.sv
// Directed self-checking bench for ds3502_wiper_ramp with a behavioural
// DS3502 writer model (configurable busy-rise delay and busy length).
module tb_ds3502_wiper_ramp;

    localparam int unsigned STEP    = 8;
    localparam int unsigned DWELL   = 20;
    localparam int unsigned INITC   = 64;
    localparam int unsigned MAXC    = 120;
    localparam int unsigned TIMEOUT = 100;

    logic       clk;
    logic       rst;
    logic       tgt_valid;
    logic [6:0] tgt_code;
    logic       tgt_ready;
    logic       wr_load;
    logic [7:0] wr_value;
    logic       wr_busy;
    logic [6:0] cur_code;
    logic       at_target;
    logic       ramp_busy;
`ifdef DS3502_RAMP_TIMEOUT_EN
    logic       err_timeout;
`endif

    int total;
    int bad;

    ds3502_wiper_ramp #(
        .STEP           (STEP),
        .DWELL_CYCLES   (DWELL),
        .INIT_CODE      (INITC),
        .MAX_CODE       (MAXC)
`ifdef DS3502_RAMP_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TIMEOUT)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tgt_valid   (tgt_valid),
        .tgt_code    (tgt_code),
        .tgt_ready   (tgt_ready),
        .wr_load     (wr_load),
        .wr_value    (wr_value),
        .wr_busy     (wr_busy),
        .cur_code    (cur_code),
        .at_target   (at_target),
        .ramp_busy   (ramp_busy)
`ifdef DS3502_RAMP_TIMEOUT_EN
        ,
        .err_timeout (err_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Writer model: busy rises rise_dly cycles after a load, stays high hold cycles.
    int   rise_dly;
    int   hold;
    bit   force_busy;
    bit   ignore_load;
    int   wstate;
    int   wcnt;

    always @(posedge clk) begin
        if (rst) begin
            wstate <= 0;
            wcnt   <= 0;
        end else begin
            case (wstate)
                0: if (wr_load && !ignore_load) begin
                    if (rise_dly <= 1) begin
                        wstate <= 2;
                        wcnt   <= hold - 1;
                    end else begin
                        wstate <= 1;
                        wcnt   <= rise_dly - 2;
                    end
                end
                1: if (wcnt == 0) begin
                    wstate <= 2;
                    wcnt   <= hold - 1;
                end else begin
                    wcnt <= wcnt - 1;
                end
                default: if (wcnt == 0) wstate <= 0; else wcnt <= wcnt - 1;
            endcase
        end
    end

    assign wr_busy = force_busy || (wstate == 2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Protocol monitor: logs writes and checks strobe/hold/dwell rules.
    logic [7:0] wlog[$];
    logic [7:0] held;
    bit         pending;
    bit         prev_load;
    bit         prev_busy;
    bit         fall_valid;
    int         last_fall;
    int         cyc;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pending    = 1'b0;
            fall_valid = 1'b0;
        end else begin
            if (prev_load) chk("load_single_cycle", 32'(wr_load), 0);
            if (wr_load === 1'b1) begin
                chk("load_while_busy", 32'(wr_busy), 0);
                if (fall_valid) chk("dwell_gap", 32'((cyc - last_fall) >= DWELL), 1);
                wlog.push_back(wr_value);
                held    = wr_value;
                pending = 1'b1;
            end
            if (prev_busy && !wr_busy && pending) begin
                chk("value_stable", 32'(wr_value), 32'(held));
                pending    = 1'b0;
                last_fall  = cyc;
                fall_valid = 1'b1;
            end
        end
        prev_load = wr_load;
        prev_busy = wr_busy;
    end

    int expq[$];

    task automatic check_log(input string tag);
        chk({tag, "_count"}, 32'(wlog.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            chk($sformatf("%s_w%0d", tag, i),
                (i < wlog.size()) ? 32'(wlog[i]) : 32'hFFFF_FFFF, 32'(expq[i]));
        end
    endtask

    task automatic send_target(input logic [6:0] code);
        tgt_valid = 1'b1;
        tgt_code  = code;
        @(negedge clk);
        tgt_valid = 1'b0;
    endtask

    task automatic wait_settled(input int limit, input string tag);
        int n;
        n = 0;
        while (!(at_target === 1'b1) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_settled"}, 32'(n < limit), 1);
    endtask

    task automatic wait_load(input int limit, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wr_load !== 1'b1 && n < limit);
        chk({tag, "_load_seen"}, 32'(n < limit), 1);
    endtask

    initial begin
        int mx;
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        tgt_valid   = 1'b0;
        tgt_code    = '0;
        force_busy  = 1'b1;
        ignore_load = 1'b0;
        rise_dly    = 1;
        hold        = 10;

        // Reset values, then writer held busy for 20 cycles after release.
        repeat (3) @(negedge clk);
        chk("rst_wr_load", 32'(wr_load), 0);
        chk("rst_wr_value", 32'(wr_value), 0);
        chk("rst_cur_code", 32'(cur_code), INITC);
        chk("rst_at_target", 32'(at_target), 0);
        chk("rst_ramp_busy", 32'(ramp_busy), 1);
        chk("rst_tgt_ready", 32'(tgt_ready), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("init_no_load_while_busy", 32'(wlog.size()), 0);
        chk("init_tgt_ready", 32'(tgt_ready), 0);
        force_busy = 1'b0;
        wait_settled(200, "init");
        expq = '{8'h40};
        check_log("init");
        chk("init_cur_code", 32'(cur_code), 64);
        chk("init_tgt_ready_up", 32'(tgt_ready), 1);

        // Ramp 64 -> 100 with two-cycle target-to-load latency.
        wlog.delete();
        tgt_valid = 1'b1;
        tgt_code  = 7'd100;
        @(negedge clk);
        tgt_valid = 1'b0;
        chk("lat_at_target_drop", 32'(at_target), 0);
        @(negedge clk);
        chk("lat_no_load_yet", 32'(wr_load), 0);
        @(negedge clk);
        chk("lat_load_cycle2", 32'(wr_load), 1);
        wait_settled(2000, "up100");
        expq = '{72, 80, 88, 96, 100};
        check_log("up100");
        chk("up100_cur_code", 32'(cur_code), 100);
        chk("up100_idle", 32'(ramp_busy), 0);

        // Reset mid-write re-synchronises through the INIT write.
        send_target(7'd20);
        wait_load(200, "midrst");
        repeat (3) @(negedge clk);
        rst        = 1'b1;
        force_busy = 1'b1;
        wlog.delete();
        @(negedge clk);
        chk("midrst_cur_code", 32'(cur_code), INITC);
        chk("midrst_wr_value", 32'(wr_value), 0);
        chk("midrst_ramp_busy", 32'(ramp_busy), 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        force_busy = 1'b0;
        wait_settled(300, "midrst");
        expq = '{8'h40};
        check_log("midrst");

        // Reverse direction while the write of 80 is in flight.
        wlog.delete();
        send_target(7'd100);
        wait_load(200, "rev_first");
        wait_load(200, "rev_second");
        chk("rev_inflight_value", 32'(wr_value), 80);
        send_target(7'd10);
        wait_settled(3000, "rev");
        expq = '{72, 80, 72, 64, 56, 48, 40, 32, 24, 16, 10};
        check_log("rev");
        mx = 0;
        foreach (wlog[i]) if (int'(wlog[i]) > mx) mx = int'(wlog[i]);
        chk("rev_no_overshoot", 32'(mx <= 80), 1);
        chk("rev_cur_code", 32'(cur_code), 10);

        // Clamp: 7'h7F with MAX_CODE=120 ends at 120.
        wlog.delete();
        send_target(7'h7F);
        wait_settled(3000, "clamp");
        expq = '{18, 26, 34, 42, 50, 58, 66, 74, 82, 90, 98, 106, 114, 120};
        check_log("clamp");
        chk("clamp_cur_code", 32'(cur_code), MAXC);
        wlog.delete();
        send_target(7'd127);
        repeat (40) @(negedge clk);
        chk("repeat127_no_load", 32'(wlog.size()), 0);
        chk("repeat127_at_target", 32'(at_target), 1);
        send_target(7'd120);
        repeat (40) @(negedge clk);
        chk("repeat120_no_load", 32'(wlog.size()), 0);
        chk("repeat120_at_target", 32'(at_target), 1);

        // Slow writer: busy rises 3 cycles late and stays high 500 cycles.
        rise_dly = 3;
        hold     = 500;
        wlog.delete();
        send_target(7'd110);
        wait_settled(3000, "slow");
        expq = '{112, 110};
        check_log("slow");
        chk("slow_cur_code", 32'(cur_code), 110);
        rise_dly = 1;
        hold     = 10;

`ifdef DS3502_RAMP_TIMEOUT_EN
        // Busy never rises: watchdog fires after TIMEOUT cycles in ACCEPT, then retries.
        begin
            int n;
            ignore_load = 1'b1;
            wlog.delete();
            send_target(7'd100);
            wait_load(200, "wd_first");
            n = 0;
            while (err_timeout !== 1'b1 && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("wd_fire_cycle", 32'(n), TIMEOUT);
            chk("wd_err", 32'(err_timeout), 1);
            chk("wd_cur_unchanged", 32'(cur_code), 110);
            wait_load(300, "wd_retry");
            chk("wd_retry_value", 32'(wr_value), 102);
            ignore_load = 1'b0;
            wait_settled(3000, "wd");
            chk("wd_final_code", 32'(cur_code), 100);
            chk("wd_err_sticky", 32'(err_timeout), 1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
